// File: rtl/s_term_uio_pkg.sv
// Shared widths, UIO pin bit positions and the RX entry type for the
// south-terminal user IO bridge.
package s_term_uio_pkg;
  localparam int UIO_W        = 20;
  localparam int DATA_W       = 16;
  localparam int UIO_DATA_LSB = 0;
  localparam int UIO_VALID    = 16;
  localparam int UIO_LAST     = 17;
  localparam int UIO_CREDIT   = 18;
  localparam int UIO_CTRL     = 19;

  typedef struct packed {
    logic              last;
    logic [DATA_W-1:0] data;
  } rx_entry_t;
endpackage

// File: rtl/s_term_uio_rx_fifo.sv
// Synchronous RX FIFO; a push while full is taken when a pop happens in the
// same cycle.
module s_term_uio_rx_fifo
  import s_term_uio_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                       gclk,
  input  logic                       grst,
  input  logic                       push,
  input  logic                       pop,
  input  rx_entry_t                  din,
  output rx_entry_t                  dout,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       empty,
  output logic                       full
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  rx_entry_t         mem [DEPTH];
  logic [AW-1:0]     wr_ptr, rd_ptr;
  logic              do_push, do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rd_ptr];

  // DEPTH is a power of two, so the pointers wrap on their own.
  always_ff @(posedge gclk) begin
    if (grst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge gclk) begin
    if (do_push) mem[wr_ptr] <= din;
  end
endmodule

// File: rtl/s_term_uio_bridge.sv
// Host-side endpoint of the bottom-edge UIO link: valid/ready streams on the
// host side, registered credit-based word protocol on the UIO pins.
module s_term_uio_bridge
  import s_term_uio_pkg::*;
#(
  parameter int TX_CREDITS = 4,
  parameter int RX_DEPTH   = 4
) (
  input  logic              UserCLK,
  input  logic              Reset,
  input  logic              link_en,
  input  logic [15:0]       s_data,
  input  logic              s_last,
  input  logic              s_valid,
  output logic              s_ready,
  output logic [15:0]       m_data,
  output logic              m_last,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [19:0]       UIO_BOT_FOUT,
  input  logic [19:0]       UIO_BOT_FIN,
  output logic [2:0]        tx_credits,
  output logic              rx_overflow,
  output logic              credit_err,
  output logic              fabric_err
);
  localparam int CW = $clog2(RX_DEPTH) + 1;
  localparam logic [2:0] CRED_MAX = 3'(TX_CREDITS);

  logic [UIO_W-1:0]  fin_q;
  logic              rst_q;
  logic [DATA_W-1:0] fout_data;
  logic              fout_vld, fout_last, fout_crd, fout_en;
  logic [2:0]        credits;
  logic              send, crd_in, push, pop;
  logic              rx_full, rx_empty;
  logic [CW-1:0]     rx_count;
  rx_entry_t         rx_in, rx_head;

  // rst_q keeps s_ready low for the first cycle after reset release.
  assign s_ready = link_en && (credits != 3'd0) && !Reset && !rst_q;
  assign send    = s_valid && s_ready;
  assign crd_in  = fin_q[UIO_CREDIT];
  assign push    = fin_q[UIO_VALID] && link_en;
  assign m_valid = (rx_count != '0);
  assign pop     = m_valid && m_ready;
  assign rx_in   = '{last: fin_q[UIO_LAST], data: fin_q[UIO_DATA_LSB +: DATA_W]};

  always_ff @(posedge UserCLK) begin
    if (Reset) begin
      fin_q       <= '0;
      rst_q       <= 1'b1;
      fout_data   <= '0;
      fout_vld    <= 1'b0;
      fout_last   <= 1'b0;
      fout_crd    <= 1'b0;
      fout_en     <= 1'b0;
      credits     <= CRED_MAX;
      rx_overflow <= 1'b0;
      credit_err  <= 1'b0;
    end else begin
      fin_q     <= UIO_BOT_FIN;
      rst_q     <= 1'b0;
      if (send) fout_data <= s_data;
      fout_vld  <= send;
      fout_last <= send && s_last;
      fout_crd  <= pop;
      fout_en   <= link_en;
      // A send and a returned credit in the same cycle cancel out.
      if (send && !crd_in) begin
        credits <= credits - 3'd1;
      end else if (crd_in && !send) begin
        if (credits == CRED_MAX) credit_err <= 1'b1;
        else                     credits    <= credits + 3'd1;
      end
      if (push && rx_full && !pop) rx_overflow <= 1'b1;
    end
  end

  s_term_uio_rx_fifo #(.DEPTH(RX_DEPTH)) u_rx_fifo (
    .gclk  (UserCLK),
    .grst  (Reset),
    .push  (push),
    .pop   (pop),
    .din   (rx_in),
    .dout  (rx_head),
    .count (rx_count),
    .empty (rx_empty),
    .full  (rx_full)
  );

  // Head storage is not reset; hold the data outputs at zero while empty.
  assign m_data       = rx_empty ? '0 : rx_head.data;
  assign m_last       = rx_empty ? 1'b0 : rx_head.last;
  assign UIO_BOT_FOUT = {fout_en, fout_crd, fout_last, fout_vld, fout_data};
  assign tx_credits   = credits;
  assign fabric_err   = fin_q[UIO_CTRL];
endmodule
